// File: rtl/chip_io_pkg.sv
// rtl/chip_io_pkg.sv - beat-count helpers, input FSM states and pin width check for chip_io_bridge
// The pin width check macro is expanded as a generate item inside the bridge.
`define CHIP_IO_CHECK_PIN_W(word_w, pin_w) \
  if (((word_w) % (pin_w)) != 0) begin : g_pin_w_check \
    $error("chip_io_bridge: pr*bw is not a multiple of pin_w"); \
  end

package chip_io_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } in_state_e;

  function automatic int in_beats(input int pr, input int bw, input int pin_w);
    return (pr * bw) / pin_w;
  endfunction

  function automatic int out_beats(input int bw_psum, input int col, input int pin_w);
    return (bw_psum * col + pin_w - 1) / pin_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pin_serializer.sv
// rtl/pin_serializer.sv - captures the core result bus and drains it LSB-first over the pin lane
// A capture is only taken into an empty buffer or on the final handshake; anything else is an overrun.
module pin_serializer
  import chip_io_pkg::*;
#(
  parameter int data_w = 160,
  parameter int pin_w  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap,
  input  logic [data_w-1:0] data_in,
  output logic [pin_w-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic              valid_next
);

  localparam int OUT_BEATS = out_beats(data_w, 1, pin_w);
  localparam int OBUF_W    = OUT_BEATS * pin_w;
  localparam int CNT_W     = cnt_width(OUT_BEATS);

  logic [OBUF_W-1:0] obuf_q, obuf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [pin_w-1:0]  data_q, data_d;
  logic              hs, final_hs, cap_ok;

  assign hs       = valid_q && out_ready;
  assign final_hs = hs && (cnt_q == CNT_W'(OUT_BEATS - 1));
  assign cap_ok   = cap && (!valid_q || final_hs);

  always_comb begin
    obuf_d  = obuf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q || (cap && !cap_ok);
    if (cap_ok) begin
      // Upper bits of the padded buffer stay zero so the last beat is zero-filled.
      obuf_d              = '0;
      obuf_d[data_w-1:0]  = data_in;
      cnt_d               = '0;
      valid_d             = 1'b1;
    end else if (final_hs) begin
      valid_d = 1'b0;
    end else if (hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    data_d = valid_d ? obuf_d[int'(cnt_d) * pin_w +: pin_w] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      obuf_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      obuf_q  <= obuf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign ovf        = ovf_q;
  assign valid_next = valid_d;

endmodule

// File: rtl/chip_io_bridge.sv
// rtl/chip_io_bridge.sv - pin-level bridge: assembles pin beats into core words, serialises core results
// The issue registers load on the last-beat handshake so core_inst pulses in the FSM's ISSUE cycle.
module chip_io_bridge
  import chip_io_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2 * bw + 4,
  parameter int pr      = 16,
  parameter int pin_w   = 16,
  parameter int inst_w  = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [pin_w-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [inst_w-1:0]      in_inst,
  output logic [pr*bw-1:0]       core_mem_in,
  output logic [inst_w-1:0]      core_inst,
  input  logic [bw_psum*col-1:0] core_out,
  input  logic                   cap,
  output logic [pin_w-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf,
  output logic                   busy
);

  localparam int WORD_W   = pr * bw;
  localparam int PSUM_W   = bw_psum * col;
  localparam int IN_BEATS = in_beats(pr, bw, pin_w);
  localparam int BEAT_W   = cnt_width(IN_BEATS);

  `CHIP_IO_CHECK_PIN_W(WORD_W, pin_w)

  in_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic [WORD_W-1:0] mem_in_q, mem_in_d;
  logic [inst_w-1:0] core_inst_q, core_inst_d;
  logic              busy_q, busy_d;
  logic              in_accept, last_beat, out_valid_next;

  assign in_ready  = (state_q == FILL) && !reset;
  assign in_accept = in_valid && in_ready;
  assign last_beat = (beat_q == BEAT_W'(IN_BEATS - 1));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    stage_d     = stage_q;
    mem_in_d    = mem_in_q;
    core_inst_d = '0;
    case (state_q)
      FILL: begin
        if (in_accept) begin
          stage_d[int'(beat_q) * pin_w +: pin_w] = in_data;
          if (last_beat) begin
            mem_in_d    = stage_d;
            core_inst_d = in_inst;
            beat_d      = '0;
            state_d     = ISSUE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ISSUE:   state_d = FILL;
      default: state_d = FILL;
    endcase
    busy_d = (beat_d != '0) || out_valid_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      beat_q      <= '0;
      stage_q     <= '0;
      mem_in_q    <= '0;
      core_inst_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      stage_q     <= stage_d;
      mem_in_q    <= mem_in_d;
      core_inst_q <= core_inst_d;
      busy_q      <= busy_d;
    end
  end

  assign core_mem_in = mem_in_q;
  assign core_inst   = core_inst_q;
  assign busy        = busy_q;

  pin_serializer #(
    .data_w (PSUM_W),
    .pin_w  (pin_w)
  ) u_pin_serializer (
    .clk        (clk),
    .reset      (reset),
    .cap        (cap),
    .data_in    (core_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .valid_next (out_valid_next)
  );

endmodule

// File: tb/tb_chip_io_bridge.sv
// tb/tb_chip_io_bridge.sv - scoreboard bench for chip_io_bridge at default parameters
module tb_chip_io_bridge;

  localparam int COL       = 8;
  localparam int BW        = 8;
  localparam int BW_PSUM   = 2 * BW + 4;
  localparam int PR        = 16;
  localparam int PIN_W     = 16;
  localparam int INST_W    = 17;
  localparam int WORD_W    = PR * BW;
  localparam int PSUM_W    = BW_PSUM * COL;
  localparam int IN_BEATS  = 8;
  localparam int OUT_BEATS = 10;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [PIN_W-1:0]    in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [INST_W-1:0]   in_inst = '0;
  logic [WORD_W-1:0]   core_mem_in;
  logic [INST_W-1:0]   core_inst;
  logic [PSUM_W-1:0]   core_out = '0;
  logic                cap = 1'b0;
  logic [PIN_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                ovf;
  logic                busy;

  chip_io_bridge #(
    .col(COL), .bw(BW), .bw_psum(BW_PSUM), .pr(PR), .pin_w(PIN_W), .inst_w(INST_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .core_mem_in(core_mem_in), .core_inst(core_inst),
    .core_out(core_out), .cap(cap),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WORD_W-1:0] mem;
    logic [INST_W-1:0] inst;
    int                at;
  } word_t;

  typedef struct {
    logic [PIN_W-1:0] d;
    int               at;
  } beat_t;

  word_t            wq[$];
  beat_t            bq[$];
  int               hs_count = 0;
  logic             held_v = 1'b0;
  logic [PIN_W-1:0] held_d = '0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a word or completes a beat handshake.
  always @(negedge clk) begin : monitor
    word_t w;
    beat_t b;
    if (!reset) begin
      if (core_inst != '0) begin
        if (wq.size() == 0) fail("issue_unexpected");
        else begin
          w = wq.pop_front();
          check("issue_word", core_mem_in, w.mem);
          check("issue_inst", core_inst, w.inst);
          check("issue_cycle", cyc, w.at);
          check("in_ready_during_issue", in_ready, 0);
        end
      end
      if (out_valid) begin
        if (held_v) check("beat_hold", out_data, held_d);
        if (out_ready) begin
          held_v = 1'b0;
          hs_count++;
          if (bq.size() == 0) fail("beat_unexpected");
          else begin
            b = bq.pop_front();
            check("beat_data", out_data, b.d);
            if (b.at >= 0) check("beat_cycle", cyc, b.at);
          end
        end else begin
          held_v = 1'b1;
          held_d = out_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [PIN_W-1:0] d, input logic [INST_W-1:0] inst, output int acc);
    int n = 0;
    in_data  = d;
    in_inst  = inst;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("in_ready_timeout");
    step();
    acc      = cyc;
    in_valid = 1'b0;
    in_inst  = '0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input logic [INST_W-1:0] inst,
                           input int stall_after, input int stall_len);
    int    acc;
    word_t e;
    for (int k = 0; k < IN_BEATS; k++) begin
      send_beat(w[k*PIN_W +: PIN_W], (k == IN_BEATS - 1) ? inst : '0, acc);
      if (k == stall_after) begin
        repeat (stall_len) step();
        check("busy_partial_word", busy, 1);
      end
    end
    e.mem  = w;
    e.inst = inst;
    e.at   = acc;
    wq.push_back(e);
  endtask

  task automatic cap_push(input logic [PSUM_W-1:0] v, input bit stamped);
    logic [OUT_BEATS*PIN_W-1:0] p;
    beat_t b;
    p = '0;
    p[PSUM_W-1:0] = v;
    core_out = v;
    cap      = 1'b1;
    for (int j = 0; j < OUT_BEATS; j++) begin
      b.d  = p[j*PIN_W +: PIN_W];
      b.at = stamped ? cyc + 1 + j : -1;
      bq.push_back(b);
    end
    step();
    cap = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (bq.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (bq.size() != 0) fail("drain_timeout");
  endtask

  localparam logic [WORD_W-1:0] W1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [WORD_W-1:0] W2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [WORD_W-1:0] W3 = 128'hDEAD_BEEF_0BAD_F00D_1111_2222_3333_4444;
  localparam logic [PSUM_W-1:0] DA = 160'hA009_A008_A007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [PSUM_W-1:0] DB = 160'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
  localparam logic [PSUM_W-1:0] DC = 160'hC909_C808_C707_C606_C505_C404_C303_C202_C101_C000;
  localparam logic [PSUM_W-1:0] DD = 160'h0D09_0D08_0D07_0D06_0D05_0D04_0D03_0D02_0D01_0D00;
  localparam logic [PSUM_W-1:0] DE = 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0001;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int hs0;
    int i;
    bit capped_b;

    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_core_inst", core_inst, 0);
    check("rst_core_mem_in", core_mem_in, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Word assembly, then a back-to-back second word at peak throughput.
    send_word(W1, 17'h1A5A5, -1, 0);
    send_word(W2, 17'h00001, -1, 0);
    repeat (3) step();

    // Input stall after beat 3.
    send_word(W1, 17'h1A5A5, 3, 5);
    repeat (3) step();
    check("word_queue_empty_1", wq.size(), 0);

    // Output drain with out_ready held high.
    out_ready = 1'b1;
    hs0 = hs_count;
    cap_push(160'h1, 1'b1);
    wait_drain();
    check("drain_valid_dropped", out_valid, 0);
    check("drain_handshakes", hs_count - hs0, OUT_BEATS);

    // Backpressure, rejected capture at beat 4, capture on the final handshake.
    out_ready = 1'b0;
    hs0 = hs_count;
    cap_push(DA, 1'b0);
    capped_b = 1'b0;
    i = 0;
    while (hs_count - hs0 < OUT_BEATS - 1 && i < 200) begin
      out_ready = (i % 3) != 1;
      cap = 1'b0;
      if (hs_count - hs0 == 4 && !capped_b) begin
        cap      = 1'b1;
        core_out = DB;
        capped_b = 1'b1;
      end
      step();
      i++;
    end
    cap = 1'b0;
    if (hs_count - hs0 != OUT_BEATS - 1) fail("backpressure_timeout");
    check("ovf_set", ovf, 1);
    out_ready = 1'b1;
    cap_push(DC, 1'b1);
    wait_drain();
    check("chain_valid_dropped", out_valid, 0);
    check("chain_handshakes", hs_count - hs0, 2 * OUT_BEATS);
    check("ovf_sticky", ovf, 1);

    // Reset mid-word and mid-drain.
    cap_push(DD, 1'b0);
    for (int k = 0; k < 5; k++) begin
      int acc;
      send_beat(W3[k*PIN_W +: PIN_W], '0, acc);
    end
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    step();
    bq.delete();
    wq.delete();
    held_v = 1'b0;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_core_inst", core_inst, 0);
    check("mid_rst_core_mem_in", core_mem_in, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_busy", busy, 0);
    step();
    check("in_ready_held_in_reset", in_ready, 0);
    reset = 1'b0;
    #1;
    check("in_ready_after_mid_reset", in_ready, 1);

    // Fresh word and fresh drain after reset.
    send_word(W3, 17'h15555, -1, 0);
    cap_push(DE, 1'b1);
    wait_drain();
    repeat (3) step();
    check("word_queue_empty_2", wq.size(), 0);
    check("beat_queue_empty", bq.size(), 0);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
